injector_pulse_scheduler: RTL and testbench

Command-side producer for the four-channel injector drive stage: accepts per-channel injection commands (start delay, pulse width), times them against a shared microsecond tick, and generates the 4-bit injector enable vector consumed by the injector power/sense stage. Each channel runs an independent delay-then-pulse state machine. Fuel/timing logic upstream issues commands; the scheduler guarantees pulse widths exact to one tick and clamps unsafe widths.

---
 rtl/injector_pulse_scheduler_pkg.sv | 26 ++
 rtl/injector_pulse_scheduler_if.sv | 27 ++
 rtl/injector_pulse_scheduler_channel_timer.sv | 114 +++++++++++
 rtl/injector_pulse_scheduler.sv | 71 +++++++
 tb/tb_injector_pulse_scheduler.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/injector_pulse_scheduler_pkg.sv
// Shared types and constants for the four-channel injector pulse scheduler.
// Holds the channel state encoding and the pulse-width clamp helper.
package ecu_injector_pkg;

  localparam int NUM_INJ       = 4;
  localparam int CNT_W_DEF     = 16;
  localparam int MAX_WIDTH_DEF = 20000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } inj_state_e;

  // Saturating minimum used to limit requested pulse widths.
  function automatic logic [31:0] clamp_u32(input logic [31:0] val, input logic [31:0] lim);
    logic [31:0] res;
    if (val > lim) begin
      res = lim;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/injector_pulse_scheduler_if.sv
// Command handshake bundle between upstream fuel/timing logic and the scheduler.
// The master issues commands; the slave answers with per-channel readiness.
interface injector_pulse_scheduler_if #(parameter int CNT_W = 16) ();

  logic             i_cmdValid;
  logic             o_cmdReady;
  logic [1:0]       i_cmdChannel;
  logic [CNT_W-1:0] i_cmdDelay;
  logic [CNT_W-1:0] i_cmdWidth;

  modport master (
    output i_cmdValid,
    output i_cmdChannel,
    output i_cmdDelay,
    output i_cmdWidth,
    input  o_cmdReady
  );

  modport slave (
    input  i_cmdValid,
    input  i_cmdChannel,
    input  i_cmdDelay,
    input  i_cmdWidth,
    output o_cmdReady
  );

endinterface

// File: rtl/injector_pulse_scheduler_channel_timer.sv
// One injector channel: delay-then-pulse sequencer counted in i_tick strobes.
// Abort forces IDLE without a done strobe; outputs are registered.
module injector_channel_timer
  import ecu_injector_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_tick,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0] i_width,
  input  logic             i_abort,
  output logic             o_enable,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  inj_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             done_q, done_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    done_d  = 1'b0;
    if (i_abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_load) begin
            if (i_width == '0) begin
              done_d = 1'b1;
            end else if (i_delay == '0) begin
              state_d = ST_PULSE;
              cnt_d   = i_width;
            end else begin
              state_d = ST_DELAY;
              cnt_d   = i_delay;
              width_d = i_width;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (i_tick) begin
            if (cnt_q == CNT_ONE) begin
              state_d = ST_PULSE;
              cnt_d   = width_q;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_PULSE: begin
          if (i_tick) begin
            if (cnt_q == CNT_ONE) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    enable_d = (state_d == ST_PULSE);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops the enable immediately.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      width_q  <= '0;
      done_q   <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      done_q   <= done_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
    end
  end

  assign o_enable = enable_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule

// File: rtl/injector_pulse_scheduler.sv
// Four-channel injector pulse scheduler: command decode, width clamp and
// readiness mux in front of one channel timer per injector.
module injector_pulse_scheduler
  import ecu_injector_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_WIDTH = MAX_WIDTH_DEF
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_tick,
  injector_pulse_scheduler_if.slave   cmd_if,
  input  logic [NUM_INJ-1:0]          i_abort,
  output logic [NUM_INJ-1:0]          o_enable,
  output logic [NUM_INJ-1:0]          o_busy,
  output logic [NUM_INJ-1:0]          o_done,
  output logic                        o_clamped
);

  logic [1:0]         ch_s;
  logic               ready_s;
  logic               clamp_s;
  logic [CNT_W-1:0]   width_s;
  logic [NUM_INJ-1:0] accept_s;
  logic [NUM_INJ-1:0] busy_s;
  logic               clamped_q, clamped_d;

  // Handshake decode: ready follows the addressed channel only.
  always_comb begin
    ch_s      = cmd_if.i_cmdChannel;
    clamp_s   = (32'(cmd_if.i_cmdWidth) > 32'(MAX_WIDTH));
    width_s   = CNT_W'(clamp_u32(32'(cmd_if.i_cmdWidth), 32'(MAX_WIDTH)));
    ready_s   = ~busy_s[ch_s] & ~i_abort[ch_s];
    accept_s  = '0;
    if (cmd_if.i_cmdValid && ready_s) begin
      accept_s[ch_s] = 1'b1;
      clamped_d      = clamp_s;
    end else begin
      clamped_d      = 1'b0;
    end
  end

  // Clamp strobe register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      clamped_q <= 1'b0;
    end else begin
      clamped_q <= clamped_d;
    end
  end

  for (genvar g = 0; g < NUM_INJ; g++) begin : g_ch
    injector_channel_timer #(.CNT_W(CNT_W)) u_timer (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_tick   (i_tick),
      .i_load   (accept_s[g]),
      .i_delay  (cmd_if.i_cmdDelay),
      .i_width  (width_s),
      .i_abort  (i_abort[g]),
      .o_enable (o_enable[g]),
      .o_busy   (busy_s[g]),
      .o_done   (o_done[g])
    );
  end

  assign cmd_if.o_cmdReady = ready_s;
  assign o_busy            = busy_s;
  assign o_clamped         = clamped_q;

endmodule

// File: tb/tb_injector_pulse_scheduler.sv
// Scoreboard bench: an absolute-tick reference model predicts enable windows,
// done and clamp strobes; a negedge monitor compares the DUT against it.
module tb_injector_pulse_scheduler;

  localparam int CW = 16;
  localparam int MW = 20000;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_tick;
  logic [3:0] i_abort;
  logic [3:0] o_enable, o_busy, o_done;
  logic       o_clamped;

  injector_pulse_scheduler_if #(.CNT_W(CW)) cmd_if ();

  injector_pulse_scheduler #(.CNT_W(CW), .MAX_WIDTH(MW)) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_tick    (i_tick),
    .cmd_if    (cmd_if),
    .i_abort   (i_abort),
    .o_enable  (o_enable),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_clamped (o_clamped)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    bit          zero;
    int unsigned cyc;
    int unsigned tick;
  } exp_t;

  exp_t        done_q[4][$];
  int unsigned clamp_q[$];
  int unsigned tc, cyc;
  bit          last_tick;
  bit   [3:0]  mbusy;
  int unsigned rise_at[4];
  int unsigned fall_at[4];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          tick_period = 1;
  bit          tick_rand = 1'b0;
  bit          abort_rand = 1'b0;
  logic [3:0]  abort_force = 4'b0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Tick and abort driver.
  initial begin
    int tk;
    tk = 0;
    i_tick = 1'b0;
    i_abort = 4'b0000;
    forever begin
      @(posedge i_clock);
      #1;
      if (tick_rand) begin
        i_tick = ($urandom_range(0, 2) == 0);
      end else begin
        tk++;
        if (tk >= tick_period) begin
          tk = 0;
          i_tick = 1'b1;
        end else begin
          i_tick = 1'b0;
        end
      end
      i_abort = abort_force |
                ((abort_rand && $urandom_range(0, 63) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000);
    end
  end

  // Reference model: tick counts at which each accepted pulse rises and falls.
  initial begin
    int unsigned ntc, ncyc, wc, dl;
    int          ch;
    bit          acc;
    exp_t        e;
    tc = 0; cyc = 0; last_tick = 1'b0; mbusy = 4'b0000;
    forever begin
      @(posedge i_clock or posedge i_reset);
      if (i_reset) begin
        tc = 0; cyc = 0; last_tick = 1'b0; mbusy = 4'b0000;
        for (int c = 0; c < 4; c++) done_q[c].delete();
        clamp_q.delete();
      end else begin
        ntc  = tc + (i_tick ? 1 : 0);
        ncyc = cyc + 1;
        ch   = int'(cmd_if.i_cmdChannel);
        acc  = cmd_if.i_cmdValid && !mbusy[ch] && !i_abort[ch];
        for (int c = 0; c < 4; c++) begin
          if (mbusy[c]) begin
            if (i_abort[c]) begin
              mbusy[c] = 1'b0;
              if (done_q[c].size() > 0) void'(done_q[c].pop_back());
            end else if (ntc == fall_at[c]) begin
              mbusy[c] = 1'b0;
            end
          end
        end
        if (acc) begin
          dl = cmd_if.i_cmdDelay;
          wc = (cmd_if.i_cmdWidth > MW) ? MW : cmd_if.i_cmdWidth;
          if (cmd_if.i_cmdWidth > MW) clamp_q.push_back(ncyc);
          e.zero = (wc == 0);
          e.cyc  = ncyc;
          e.tick = ntc + dl + wc;
          if (wc != 0) begin
            mbusy[ch]   = 1'b1;
            rise_at[ch] = ntc + dl;
            fall_at[ch] = ntc + dl + wc;
          end
          done_q[ch].push_back(e);
        end
        tc = ntc;
        cyc = ncyc;
        last_tick = i_tick;
      end
    end
  end

  // Monitor: compares every cycle and consumes expected strobes.
  initial begin
    logic [3:0] exp_en;
    int         ch;
    exp_t       e;
    int unsigned ce;
    forever begin
      @(negedge i_clock);
      if (!i_reset) begin
        for (int c = 0; c < 4; c++) exp_en[c] = mbusy[c] && (tc >= rise_at[c]);
        ch = int'(cmd_if.i_cmdChannel);
        check("enable", 32'(o_enable), 32'(exp_en));
        check("busy", 32'(o_busy), 32'(mbusy));
        check("ready", 32'(cmd_if.o_cmdReady), 32'(!mbusy[ch] && !i_abort[ch]));
        for (int c = 0; c < 4; c++) begin
          if (o_done[c]) begin
            if (done_q[c].size() == 0) begin
              check($sformatf("done_unexpected_ch%0d", c), 32'(o_done[c]), 32'd0);
            end else begin
              e = done_q[c].pop_front();
              if (e.zero) check($sformatf("done_zero_cycle_ch%0d", c), cyc, e.cyc);
              else check($sformatf("done_tick_ch%0d", c), last_tick ? tc : 32'hFFFF_FFFF, e.tick);
            end
          end
        end
        if (o_clamped) begin
          if (clamp_q.size() == 0) begin
            check("clamp_unexpected", 32'(o_clamped), 32'd0);
          end else begin
            ce = clamp_q.pop_front();
            check("clamp_cycle", cyc, ce);
          end
        end
      end
    end
  end

  task automatic send_cmd(input int ch, input int d, input int w);
    int n;
    n = 0;
    cmd_if.i_cmdChannel = 2'(ch);
    cmd_if.i_cmdDelay   = 16'(d);
    cmd_if.i_cmdWidth   = 16'(w);
    cmd_if.i_cmdValid   = 1'b1;
    @(negedge i_clock);
    while (!cmd_if.o_cmdReady && n < 3000) begin
      n++;
      @(negedge i_clock);
    end
    if (n >= 3000) check("accept_timeout", 32'(cmd_if.o_cmdReady), 32'd1);
    @(posedge i_clock);
    #1;
    cmd_if.i_cmdValid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (mbusy != 4'b0000 && n < budget) begin
      n++;
      @(negedge i_clock);
    end
    if (n >= budget) check("idle_timeout", 32'(o_busy), 32'd0);
    repeat (3) @(posedge i_clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2000000");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1;
    cmd_if.i_cmdValid = 1'b0;
    cmd_if.i_cmdChannel = 2'd0;
    cmd_if.i_cmdDelay = 16'd0;
    cmd_if.i_cmdWidth = 16'd0;
    repeat (3) @(posedge i_clock);
    #1;
    check("rst_enable", 32'(o_enable), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_clamped", 32'(o_clamped), 32'd0);
    i_reset = 1'b0;

    // Reset in the middle of a pulse.
    tick_period = 1;
    send_cmd(0, 0, 50);
    repeat (10) @(posedge i_clock);
    #2;
    check("pre_rst_enable0", 32'(o_enable[0]), 32'd1);
    i_reset = 1'b1;
    #1;
    check("async_rst_enable", 32'(o_enable), 32'd0);
    check("async_rst_busy", 32'(o_busy), 32'd0);
    check("async_rst_done", 32'(o_done), 32'd0);
    check("async_rst_clamped", 32'(o_clamped), 32'd0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;

    // Basic delayed pulse with sparse ticks.
    tick_period = 4;
    send_cmd(1, 3, 5);
    wait_idle(500);

    // Zero width: immediate done, never busy.
    send_cmd(3, 10, 0);
    wait_idle(100);

    // Clamp above the limit alongside a width exactly at the limit.
    tick_period = 1;
    send_cmd(2, 1, 30000);
    send_cmd(3, 0, MW);
    wait_idle(25000);

    // Abort mid-pulse while another channel accepts a command.
    send_cmd(0, 2, 100);
    repeat (41) @(posedge i_clock);
    #1;
    abort_force = 4'b0001;
    repeat (2) @(posedge i_clock);
    #1;
    send_cmd(1, 5, 7);
    cmd_if.i_cmdChannel = 2'd0;
    @(negedge i_clock);
    check("abort_ready_ch0", 32'(cmd_if.o_cmdReady), 32'd0);
    check("abort_enable_ch0", 32'(o_enable[0]), 32'd0);
    @(posedge i_clock);
    #1;
    abort_force = 4'b0000;
    wait_idle(500);

    // Overlapping channels with back-pressure on a busy one.
    tick_period = 2;
    send_cmd(0, 4, 20);
    send_cmd(1, 0, 10);
    send_cmd(2, 7, 3);
    send_cmd(3, 2, 15);
    send_cmd(1, 1, 4);
    send_cmd(1, 0, 1);
    wait_idle(1000);

    // Randomized traffic with random ticks and sporadic aborts.
    tick_rand = 1'b1;
    abort_rand = 1'b1;
    for (int i = 0; i < 100; i++) begin
      int ch, d, w;
      ch = int'($urandom_range(0, 3));
      d  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      w  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      send_cmd(ch, d, w);
    end
    abort_rand = 1'b0;
    wait_idle(5000);

    for (int c = 0; c < 4; c++) check($sformatf("done_pending_ch%0d", c), done_q[c].size(), 32'd0);
    check("clamp_pending", clamp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
